// File: rtl/zero_unpad.sv
// Collapses a zero-dilated (2*SIZE-1)^2 raster stream back to its SIZE x SIZE grid,
// forwarding even-row/even-col elements and flagging any nonzero discarded element.
module zero_unpad #(
  parameter int SIZE   = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_err,
  output logic              pad_err
);

  localparam int N  = 2*SIZE - 1;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0]     row_p0, col_p0;
  logic              acc_p0;
  logic              pad_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              last_p1, ferr_p1;

  logic accept, keep, at_eol, at_eof, drop_nz, load;

  // Every position, kept or dropped, stalls while the output register is occupied.
  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign keep     = !row_p0[0] && !col_p0[0];
  assign at_eol   = (col_p0 == LAST);
  assign at_eof   = at_eol && (row_p0 == LAST);
  assign drop_nz  = accept && !keep && (in_data != '0);
  assign load     = accept && keep;

  // Stage p0: raster position and pad-error tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_p0 <= '0;
      col_p0 <= '0;
      acc_p0 <= 1'b0;
      pad_p0 <= 1'b0;
    end else if (clr) begin
      row_p0 <= '0;
      col_p0 <= '0;
      acc_p0 <= 1'b0;
      pad_p0 <= 1'b0;
    end else if (accept) begin
      if (at_eof) begin
        row_p0 <= '0;
        col_p0 <= '0;
        acc_p0 <= 1'b0;
      end else if (at_eol) begin
        row_p0 <= row_p0 + CW'(1);
        col_p0 <= '0;
      end else begin
        col_p0 <= col_p0 + CW'(1);
      end
      if (drop_nz) begin
        acc_p0 <= 1'b1;
        pad_p0 <= 1'b1;
      end
    end
  end

  // Stage p1: output register control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      ferr_p1 <= 1'b0;
    end else if (clr) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      ferr_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      last_p1 <= at_eof;
      ferr_p1 <= at_eof && acc_p0;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Stage p1: output data, untouched by clr so a held value survives an abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_p1 <= '0;
    end else if (!clr && load) begin
      data_p1 <= in_data;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign frame_err = ferr_p1;
  assign pad_err   = pad_p0;

endmodule
